// File: rtl/mem_arb_pkg.sv
// Shared types and default geometry for the two-port register-file arbiter.
// Used by mem_port_arbiter and rr_arb2.
package mem_arb_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 8;
  localparam int DEF_ADDR_W = 4;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Selects requester 0 or 1.
  typedef logic req_idx_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker. Under contention it grants the requester that was not
// granted last; the last-granted pointer moves only when an access is accepted.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] gnt_o
);

  req_idx_t last_q;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    gnt_o = 2'b00;
    if (req_i == 2'b11) begin
      gnt_o = (last_q == 1'b1) ? 2'b01 : 2'b10;
    end else begin
      gnt_o = req_i;
    end
  end

  // Reset value 1 means rq1 was "last", so rq0 wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (accept_i && (gnt_o != 2'b00)) begin
      // NOTE: flops use non-blocking assignment so every register samples pre-edge values.
      last_q <= gnt_o[1];
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter and zero-initialiser for a single-port register file.
// Define MEM_ARB_INIT_EN to compile in the post-reset zero sweep (ST_INIT).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rq0_req,
  input  logic              rq0_we,
  input  logic [ADDR_W-1:0] rq0_addr,
  input  logic [DATA_W-1:0] rq0_wdata,
  output logic              rq0_gnt,
  output logic              rq0_rvalid,
  output logic [DATA_W-1:0] rq0_rdata,
  input  logic              rq1_req,
  input  logic              rq1_we,
  input  logic [ADDR_W-1:0] rq1_addr,
  input  logic [DATA_W-1:0] rq1_wdata,
  output logic              rq1_gnt,
  output logic              rq1_rvalid,
  output logic [DATA_W-1:0] rq1_rdata,
  output logic              mem_wen,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              init_done
);

  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

  state_e            state_q;
  logic              sweeping;
  logic              run;
  logic [ADDR_W-1:0] sweep_addr;

`ifdef MEM_ARB_INIT_EN
  logic [ADDR_W-1:0] sweep_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      sweep_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_INIT: begin
          if (sweep_cnt_q == ADDR_W'(DEPTH - 1)) begin
            state_q <= ST_RUN;
          end else begin
            sweep_cnt_q <= sweep_cnt_q + 1'b1;
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  assign sweep_addr = sweep_cnt_q;
  // NOTE: gated with rst_n so mem_wen and the grants are 0 while reset is held.
  assign sweeping   = rst_n && (state_q == ST_INIT);
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= ST_RUN;
    end
  end

  assign sweep_addr = '0;
  assign sweeping   = 1'b0;
`endif

  assign run       = rst_n && (state_q == ST_RUN);
  assign init_done = (state_q == ST_RUN);

  logic [1:0] gnt;

  rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_i   ({rq1_req & run, rq0_req & run}),
    .accept_i(run),
    .gnt_o   (gnt)
  );

  assign rq0_gnt = gnt[0];
  assign rq1_gnt = gnt[1];

  req_idx_t          sel;
  logic              acc;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              in_range;

  assign sel       = gnt[1];
  assign acc       = (gnt != 2'b00);
  assign sel_we    = sel ? rq1_we    : rq0_we;
  assign sel_addr  = sel ? rq1_addr  : rq0_addr;
  assign sel_wdata = sel ? rq1_wdata : rq0_wdata;
  assign in_range  = ({1'b0, sel_addr} < DEPTH_LIM);

  // Out-of-range writes are granted but never reach the array.
  always_comb begin
    mem_wen   = 1'b0;
    mem_ren   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (sweeping) begin
      mem_wen  = 1'b1;
      mem_addr = sweep_addr;
    end else if (acc) begin
      mem_wen   = sel_we & in_range;
      mem_ren   = ~sel_we;
      mem_addr  = sel_addr;
      mem_wdata = sel_wdata;
    end
  end

  logic [1:0]             rvalid_q;
  logic [1:0][DATA_W-1:0] rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= '0;
      if (acc && !sel_we) begin
        rvalid_q[sel] <= 1'b1;
        rdata_q[sel]  <= in_range ? mem_rdata : '0;
      end
    end
  end

  assign rq0_rvalid = rvalid_q[0];
  assign rq1_rvalid = rvalid_q[1];
  assign rq0_rdata  = rdata_q[0];
  assign rq1_rdata  = rdata_q[1];

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural register file and read-data
// scoreboards; adapts to builds with or without MEM_ARB_INIT_EN.
module tb_mem_port_arbiter;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 4;

`ifdef MEM_ARB_INIT_EN
  localparam logic INIT_RST = 1'b0;
`else
  localparam logic INIT_RST = 1'b1;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              rq0_req, rq0_we, rq1_req, rq1_we;
  logic [ADDR_W-1:0] rq0_addr, rq1_addr;
  logic [DATA_W-1:0] rq0_wdata, rq1_wdata;
  logic              rq0_gnt, rq1_gnt, rq0_rvalid, rq1_rvalid;
  logic [DATA_W-1:0] rq0_rdata, rq1_rdata;
  logic              mem_wen, mem_ren, init_done;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .rq0_req(rq0_req), .rq0_we(rq0_we), .rq0_addr(rq0_addr), .rq0_wdata(rq0_wdata),
    .rq0_gnt(rq0_gnt), .rq0_rvalid(rq0_rvalid), .rq0_rdata(rq0_rdata),
    .rq1_req(rq1_req), .rq1_we(rq1_we), .rq1_addr(rq1_addr), .rq1_wdata(rq1_wdata),
    .rq1_gnt(rq1_gnt), .rq1_rvalid(rq1_rvalid), .rq1_rdata(rq1_rdata),
    .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .init_done(init_done)
  );

  // Behavioural array; out-of-range reads return a non-zero pattern on purpose.
  logic [DATA_W-1:0] fake_mem [DEPTH] = '{default: 8'h33};
  always @(posedge clk) if (mem_wen) fake_mem[mem_addr[2:0]] <= mem_wdata;
  assign mem_rdata = (mem_addr < 4'd8) ? fake_mem[mem_addr[2:0]] : 8'hEE;

  int total = 0;
  int bad   = 0;
  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic [DATA_W-1:0] exp0_q [$];
  logic [DATA_W-1:0] exp1_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drv0(input logic req, input logic we, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d);
    rq0_req = req; rq0_we = we; rq0_addr = a; rq0_wdata = d;
  endtask

  task automatic drv1(input logic req, input logic we, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d);
    rq1_req = req; rq1_we = we; rq1_addr = a; rq1_wdata = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_gnt0"},   32'(rq0_gnt), 0);
    check({tag, "_gnt1"},   32'(rq1_gnt), 0);
    check({tag, "_rv0"},    32'(rq0_rvalid), 0);
    check({tag, "_rv1"},    32'(rq1_rvalid), 0);
    check({tag, "_rd0"},    32'(rq0_rdata), 0);
    check({tag, "_rd1"},    32'(rq1_rdata), 0);
    check({tag, "_wen"},    32'(mem_wen), 0);
    check({tag, "_ren"},    32'(mem_ren), 0);
    check({tag, "_addr"},   32'(mem_addr), 0);
    check({tag, "_wdata"},  32'(mem_wdata), 0);
    check({tag, "_idone"},  32'(init_done), 32'(INIT_RST));
  endtask

  // Read-data scoreboard: every rvalid pulse consumes one expected value.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rq0_rvalid) begin
        if (exp0_q.size() == 0) check("rv0_spurious", 32'(rq0_rvalid), 0);
        else check("sb_rd0", 32'(rq0_rdata), 32'(exp0_q.pop_front()));
      end
      if (rq1_rvalid) begin
        if (exp1_q.size() == 0) check("rv1_spurious", 32'(rq1_rvalid), 0);
        else check("sb_rd1", 32'(rq1_rdata), 32'(exp1_q.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic g1;
    int   k;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h33;
    rst_n = 1'b0;
    drv0(0, 0, 0, 0);
    drv1(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check_reset("rst0");

`ifdef MEM_ARB_INIT_EN
    // First sweep, interrupted by reset at address 4.
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("sw1_wen",   32'(mem_wen), 1);
      check("sw1_addr",  32'(mem_addr), 32'(i));
      check("sw1_wdata", 32'(mem_wdata), 0);
      check("sw1_idone", 32'(init_done), 0);
    end
    tick();
    check("sw1_addr4", 32'(mem_addr), 4);
    rst_n = 1'b0;
    #1;
    check_reset("rst_mid");
    tick();
    // Requests held during the full sweep must wait.
    drv0(1, 0, 2, 0);
    drv1(1, 1, 6, 8'h3C);
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      check("sw2_wen",   32'(mem_wen), 1);
      check("sw2_addr",  32'(mem_addr), 32'(i));
      check("sw2_wdata", 32'(mem_wdata), 0);
      check("sw2_gnt0",  32'(rq0_gnt), 0);
      check("sw2_gnt1",  32'(rq1_gnt), 0);
      check("sw2_idone", 32'(init_done), 0);
    end
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
`else
    drv0(1, 0, 2, 0);
    drv1(1, 1, 6, 8'h3C);
    rst_n = 1'b1;
`endif

    // First RUN cycle: both pending, pointer favours rq0.
    @(negedge clk);
    check("run_idone", 32'(init_done), 1);
    check("run_gnt0",  32'(rq0_gnt), 1);
    check("run_gnt1",  32'(rq1_gnt), 0);
    check("run_ren",   32'(mem_ren), 1);
    check("run_addr",  32'(mem_addr), 2);
    exp0_q.push_back(ref_mem[2]);
    tick();
    drv0(0, 0, 0, 0);
    @(negedge clk);
    check("run_w_gnt0",  32'(rq0_gnt), 0);
    check("run_w_gnt1",  32'(rq1_gnt), 1);
    check("run_w_wen",   32'(mem_wen), 1);
    check("run_w_addr",  32'(mem_addr), 6);
    check("run_w_wdata", 32'(mem_wdata), 32'h3C);
    ref_mem[6] = 8'h3C;
    tick();
    drv1(0, 0, 0, 0);

    // Back-to-back readback of the whole array.
    for (int i = 0; i < DEPTH; i++) begin
      drv0(1, 0, ADDR_W'(i), 0);
      @(negedge clk);
      check("rb_gnt0", 32'(rq0_gnt), 1);
      exp0_q.push_back(ref_mem[i]);
      tick();
    end
    drv0(0, 0, 0, 0);
    @(negedge clk);
    check("idle_gnt0", 32'(rq0_gnt), 0);
    check("idle_gnt1", 32'(rq1_gnt), 0);
    check("idle_wen",  32'(mem_wen), 0);
    check("idle_ren",  32'(mem_ren), 0);
    check("idle_addr", 32'(mem_addr), 0);
    tick();
    @(negedge clk);
    check("hold_rv0", 32'(rq0_rvalid), 0);
    check("hold_rd0", 32'(rq0_rdata), 32'(ref_mem[7]));
    tick();

    // Write then read the same address on consecutive cycles.
    drv0(1, 1, 3, 8'hA5);
    @(negedge clk);
    check("wr3_gnt0",  32'(rq0_gnt), 1);
    check("wr3_wen",   32'(mem_wen), 1);
    check("wr3_ren",   32'(mem_ren), 0);
    check("wr3_addr",  32'(mem_addr), 3);
    check("wr3_wdata", 32'(mem_wdata), 32'hA5);
    ref_mem[3] = 8'hA5;
    tick();
    drv0(1, 0, 3, 0);
    @(negedge clk);
    check("rd3_gnt0", 32'(rq0_gnt), 1);
    check("rd3_ren",  32'(mem_ren), 1);
    check("rd3_wen",  32'(mem_wen), 0);
    exp0_q.push_back(ref_mem[3]);
    tick();
    drv0(0, 0, 0, 0);
    @(negedge clk);
    check("rd3_rv0", 32'(rq0_rvalid), 1);
    check("rd3_rd0", 32'(rq0_rdata), 32'hA5);
    tick();

    // rq1 write leaves the pointer on rq1; contention then alternates from rq0.
    drv1(1, 1, 5, 8'h5A);
    @(negedge clk);
    check("wr5_gnt1",  32'(rq1_gnt), 1);
    check("wr5_wen",   32'(mem_wen), 1);
    check("wr5_addr",  32'(mem_addr), 5);
    check("wr5_wdata", 32'(mem_wdata), 32'h5A);
    ref_mem[5] = 8'h5A;
    tick();
    drv0(1, 0, 3, 0);
    drv1(1, 0, 6, 0);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      g1 = j[0];
      check("rra_gnt0", 32'(rq0_gnt), 32'(!g1));
      check("rra_gnt1", 32'(rq1_gnt), 32'(g1));
      if (j > 0) begin
        check("rra_rv0", 32'(rq0_rvalid), 32'(g1));
        check("rra_rv1", 32'(rq1_rvalid), 32'(!g1));
      end
      if (g1) exp1_q.push_back(ref_mem[6]);
      else exp0_q.push_back(ref_mem[3]);
      tick();
    end
    drv0(0, 0, 0, 0);
    drv1(0, 0, 0, 0);
    @(negedge clk);
    check("rra_end_rv0", 32'(rq0_rvalid), 1);
    tick();
    @(negedge clk);
    tick();
    // Idle cycles must not move the pointer: rq0 was last, so rq1 wins now.
    drv0(1, 0, 3, 0);
    drv1(1, 0, 6, 0);
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      g1 = !j[0];
      check("rrb_gnt0", 32'(rq0_gnt), 32'(!g1));
      check("rrb_gnt1", 32'(rq1_gnt), 32'(g1));
      if (g1) exp1_q.push_back(ref_mem[6]);
      else exp0_q.push_back(ref_mem[3]);
      tick();
    end
    drv0(0, 0, 0, 0);
    drv1(0, 0, 0, 0);

    // Out-of-range address 9: granted, write dropped, read returns 0.
    drv1(1, 1, 9, 8'hFF);
    @(negedge clk);
    check("oor_w_gnt1", 32'(rq1_gnt), 1);
    check("oor_w_wen",  32'(mem_wen), 0);
    tick();
    drv1(1, 0, 9, 0);
    @(negedge clk);
    check("oor_r_gnt1", 32'(rq1_gnt), 1);
    exp1_q.push_back('0);
    tick();
    drv1(1, 0, 1, 0);
    @(negedge clk);
    check("oor_r_rv1", 32'(rq1_rvalid), 1);
    check("oor_r_rd1", 32'(rq1_rdata), 0);
    exp1_q.push_back(ref_mem[1]);
    tick();
    drv1(0, 0, 0, 0);
    @(negedge clk);
    tick();

    // Reset while a read result is pending: rvalid is lost, pointer returns to rq0.
    drv0(1, 0, 3, 0);
    @(negedge clk);
    check("prr_gnt0", 32'(rq0_gnt), 1);
    tick();
    rst_n = 1'b0;
    drv0(0, 0, 0, 0);
    #1;
    check_reset("rst_acc");
    exp0_q.delete();
    exp1_q.delete();
    tick();
    drv0(1, 0, 3, 0);
    drv1(1, 0, 5, 0);
    rst_n = 1'b1;
`ifdef MEM_ARB_INIT_EN
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
`endif
    k = 0;
    @(negedge clk);
    while (!init_done && k < 20) begin
      check("re_wait_gnt0", 32'(rq0_gnt), 0);
      k++;
      @(negedge clk);
    end
    check("re_idone", 32'(init_done), 1);
    check("re_gnt0",  32'(rq0_gnt), 1);
    check("re_gnt1",  32'(rq1_gnt), 0);
    exp0_q.push_back(ref_mem[3]);
    tick();
    drv0(0, 0, 0, 0);
    @(negedge clk);
    check("re_gnt1b", 32'(rq1_gnt), 1);
    exp1_q.push_back(ref_mem[5]);
    tick();
    drv1(0, 0, 0, 0);
    repeat (2) begin
      @(negedge clk);
      tick();
    end

    check("sb0_empty", 32'(exp0_q.size()), 0);
    check("sb1_empty", 32'(exp1_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and initialiser for the small single-port register-file memory (DEPTH x DATA_W, one access per cycle, combinational read, clocked write). It sits between two independent client blocks and the memory, grants at most one access per cycle with round-robin fairness, and returns read data registered one cycle later. It optionally sweeps the array to zero after reset so the memory itself needs no reset on its storage.

## Interface
- DATA_W, 8, data width
- DEPTH, 8, number of memory entries
- ADDR_W, 4, address width (must satisfy 2**ADDR_W >= DEPTH)

- clk  in  1  clock
- rst_n  in  1  reset: asynchronous, active-low
- rq0_req / rq1_req  in  1  access request, held until granted
- rq0_we / rq1_we  in  1  1 = write, 0 = read
- rq0_addr / rq1_addr  in  ADDR_W  entry address
- rq0_wdata / rq1_wdata  in  DATA_W  write data
- rq0_gnt / rq1_gnt  out  1  combinational accept; the access completes at the edge where req & gnt
- rq0_rvalid / rq1_rvalid  out  1  registered, one-cycle pulse, read data valid
- rq0_rdata / rq1_rdata  out  DATA_W  registered read data; holds its last value when rvalid is low
- mem_wen  out  1  memory write enable
- mem_ren  out  1  memory read enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, combinational from mem_addr
- init_done  out  1  high once the memory is usable

## Operation
- FSM states:
  - ST_INIT: zero sweep. All gnt are low.
  - ST_RUN: arbitration.
- ST_INIT sequence:
  - A counter drives mem_addr = 0..DEPTH-1 with mem_wen=1 and mem_wdata=0.
  - After address DEPTH-1 is written, the FSM moves to ST_RUN and init_done goes high.
- ST_RUN, single request: the requester is granted in the same cycle. gnt = req & (no contention, or it is this requester's turn).
- ST_RUN, both requesting:
  - The requester not granted last wins.
  - The last-granted pointer updates only on an accepted access.
  - After reset the pointer favours rq0.
  - The loser keeps req and its payload stable, and is granted on the next cycle at the latest.
- The granted requester's we, addr and wdata are muxed combinationally onto mem_*:
  - mem_wen = accepted write.
  - mem_ren = accepted read.
  - When idle, mem_* are 0.
- Read accept: mem_rdata is captured into that requester's rdata at the edge. rvalid pulses for exactly the following cycle.
- Address >= DEPTH: the access is still granted. A write is dropped (mem_wen=0). A read returns rdata=0 with rvalid=1.
- Back-to-back accesses from one requester are accepted every cycle.
- A read following a write to the same address in the next cycle returns the new data.
- Reset values:
  - All gnt, rvalid, mem_wen, mem_ren: 0.
  - All rdata, mem_addr, mem_wdata: 0.
  - init_done: 0 when the sweep is enabled, otherwise 1.
- Reset asserted mid-sweep or mid-access: all state clears asynchronously. The sweep restarts from address 0 and any pending rvalid is lost.

## Timing
- Grant latency: 0 cycles uncontended; at most 1 cycle of wait under contention.
- Read latency: rvalid is asserted 1 cycle after the accepting edge.
- Write is visible in the memory after the accepting edge.
- Init: DEPTH cycles after rst_n deasserts.
  - mem_wen is high in cycles 0..DEPTH-1.
  - init_done is registered high from cycle DEPTH.
  - Requests during init wait with gnt low.
- Throughput: one access per cycle total.

## Configuration
- MEM_ARB_INIT_EN:
  - Defined: ST_INIT and the zero sweep are compiled in.
  - Undefined: the sweep counter and ST_INIT are removed. The FSM resets directly into ST_RUN, init_done is tied to 1, and memory contents are undefined until written.

## Structure
- Package mem_arb_pkg:
  - State enum (ST_INIT, ST_RUN).
  - Default DATA_W/DEPTH/ADDR_W localparams.
  - Requester index typedef (1 bit).
- Sub-module rr_arb2: two-way round-robin picker.
  - Inputs: req[1:0], accept.
  - Output: one-hot gnt[1:0].
  - Owns the last-granted flop.
- Top module: FSM, sweep counter, payload mux, range check, rdata/rvalid registers.

## Test plan
- Reset release with the sweep enabled: mem_wen high for 8 cycles at addresses 0..7 with wdata 0, then init_done=1. Reading any address then returns 0.
- rq0 writes 0xA5 to addr 3, then reads addr 3 on the next cycle: rq0_gnt same cycle both times; rq0_rvalid one cycle after the read with rq0_rdata=0xA5.
- Both requesters hold reads from cycle 0: rq0 is granted first, rq1 next cycle, then they alternate. rvalid pulses are one cycle after each respective grant.
- rq1 writes to addr 9 (DEPTH=8): gnt=1, mem_wen=0. A subsequent read of addr 9 gives rvalid=1 with rdata=0.
- rst_n pulsed low at sweep address 4: all outputs return to reset values and the sweep restarts at address 0.
- Requests asserted during init: gnt stays 0 until init_done. The first grant occurs in the cycle init_done rises.
